// File: rtl/additive_inverse_processor.sv
// Fixed-program datapath: load x, form y = ~x + imm, test x + y for zero, restore x.
// A 7-state sequencer advances unconditionally once per clock after reset.
module additive_inverse_processor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;

  state_t state_q, state_d;

  // datapath controls, decoded from the state being left on this edge
  logic ld_x_imm, ld_x_sum, clr_y, inv_y, inc_y, ld_zero;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] y_inc;

  assign sum   = x + y;
  assign y_inc = y + imm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = S0;
    ld_x_imm = 1'b0;
    ld_x_sum = 1'b0;
    clr_y    = 1'b0;
    inv_y    = 1'b0;
    inc_y    = 1'b0;
    ld_zero  = 1'b0;
    case (state_q)
      S0: begin state_d = S1; ld_x_imm = 1'b1; clr_y = 1'b1; end
      S1: begin state_d = S2; inv_y = 1'b1; end
      S2: state_d = S3;
      S3: begin state_d = S4; inc_y = 1'b1; end
      S4: begin state_d = S5; ld_x_sum = 1'b1; ld_zero = 1'b1; end
      S5: begin state_d = S6; ld_x_imm = 1'b1; end
      S6: state_d = S0;
      // stray encodings recover to S0 without touching the registers
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x    <= '0;
      y    <= '0;
      zero <= 1'b0;
    end else begin
      if (ld_x_imm)      x <= imm;
      else if (ld_x_sum) x <= sum;
      if (clr_y)         y <= '0;
      else if (inv_y)    y <= ~x;
      else if (inc_y)    y <= y_inc;
      if (ld_zero)       zero <= (sum == '0);
    end
  end

endmodule

// File: tb/tb_additive_inverse_processor.sv
// Randomized and directed bench for additive_inverse_processor against a step-count model.
module tb_additive_inverse_processor;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] x, y;
  logic             zero;

  int nvec = 0;
  int nerr = 0;

  // reference model: position in the 7-step program plus register images
  int st = 0;
  int mx = 0, my = 0, mz = 0;

  additive_inverse_processor #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .imm  (imm),
    .x    (x),
    .y    (y),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    st = 0; mx = 0; my = 0; mz = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".x"}, int'(x), mx);
    chk({tag, ".y"}, int'(y), my);
    chk({tag, ".zero"}, int'(zero), mz);
  endtask

  // one clock with the given imm, then advance the model and compare
  task automatic step(input int v, input string tag);
    int s;
    imm = v[WIDTH-1:0];
    @(posedge clk);
    case (st)
      0: begin mx = v & MASK; my = 0; end
      1: my = (~mx) & MASK;
      3: my = (my + v) & MASK;
      4: begin s = (mx + my) & MASK; mz = (s == 0) ? 1 : 0; mx = s; end
      5: mx = v & MASK;
      default: ;
    endcase
    st = (st + 1) % 7;
    #1;
    check_regs(tag);
  endtask

  // a pass with explicit imm for the sampled steps and noise elsewhere
  task automatic pass3(input int a, input int b, input int c, input string tag);
    step(a, tag);
    step($urandom_range(0, MASK), tag);
    step($urandom_range(0, MASK), tag);
    step(b, tag);
    step($urandom_range(0, MASK), tag);
    step(c, tag);
    step($urandom_range(0, MASK), tag);
  endtask

  int sx[14], sy[14], sz[14];
  int tbl[7] = '{5, 0, 0, 1, 0, 5, 0};

  initial begin
    reset = 1'b0;
    imm   = '0;
    // reset held with clock running
    repeat (3) begin
      imm = 4'($urandom_range(0, MASK));
      @(posedge clk); #1;
      check_regs("rst_hold");
    end
    @(negedge clk) reset = 1'b1;

    // directed imm=5 pass with absolute expectations
    for (int i = 0; i < 7; i++) begin
      step(tbl[i], "p5");
      case (i)
        0: begin chk("p5.s0x", int'(x), 5); chk("p5.s0y", int'(y), 0); end
        1: chk("p5.s1y", int'(y), 10);
        3: chk("p5.s3y", int'(y), 11);
        4: begin chk("p5.s4x", int'(x), 0); chk("p5.s4z", int'(zero), 1); end
        5: chk("p5.s5x", int'(x), 5);
        default: ;
      endcase
    end

    // imm=0 wrap case
    step(0, "p0"); step(1, "p0");
    chk("p0.s1y", int'(y), 15);
    step(2, "p0"); step(1, "p0");
    chk("p0.s3y", int'(y), 0);
    step(9, "p0");
    chk("p0.s4x", int'(x), 0); chk("p0.s4z", int'(zero), 1);
    step(0, "p0"); step(3, "p0");

    // most-negative boundary
    step(8, "p8"); step(0, "p8"); step(0, "p8"); step(1, "p8");
    chk("p8.s3y", int'(y), 8);
    step(0, "p8");
    chk("p8.s4x", int'(x), 0); chk("p8.s4z", int'(zero), 1);
    step(8, "p8"); step(0, "p8");

    // non-inverse: zero must clear after being 1
    step(3, "p3"); step(0, "p3"); step(0, "p3"); step(0, "p3");
    chk("p3.s3y", int'(y), 12);
    step(0, "p3");
    chk("p3.s4x", int'(x), 15); chk("p3.s4z", int'(zero), 0);
    step(3, "p3"); step(0, "p3");

    // imm held at 7 for two passes: both passes identical
    for (int i = 0; i < 14; i++) begin
      step(7, "p7");
      sx[i] = int'(x); sy[i] = int'(y); sz[i] = int'(zero);
    end
    for (int i = 0; i < 7; i++) begin
      chk("p7.rep.x", sx[i + 7], sx[i]);
      chk("p7.rep.y", sy[i + 7], sy[i]);
      chk("p7.rep.z", sz[i + 7], sz[i]);
    end

    // randomized passes, including the inverse-forming imm=1 in S3 most of the time
    for (int p = 0; p < 40; p++) begin
      int a, b, c;
      a = $urandom_range(0, MASK);
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MASK) : 1;
      c = $urandom_range(0, MASK);
      pass3(a, b, c, "rnd");
    end

    // async reset in the middle of S3, checked before any clock edge
    step(6, "ar"); step(0, "ar"); step(0, "ar");
    imm = 4'd1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("ar.x", int'(x), 0);
    chk("ar.y", int'(y), 0);
    chk("ar.z", int'(zero), 0);
    @(negedge clk) reset = 1'b1;
    // restart from S0
    for (int i = 0; i < 7; i++) step(tbl[i], "ar.re");
    chk("ar.re.x", int'(x), 5);
    pass3($urandom_range(0, MASK), 1, $urandom_range(0, MASK), "ar.rnd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
